a0_uart_tx: RTL and testbench
=============================

Name: a0_uart_tx

Overview:
- Downstream consumer of the CPU's a0 result register.
- Watches a0 every cycle and queues each new value in a small FIFO.
- Drains the FIFO as 4-byte 8N1 UART frames, most significant byte first, so program results reach a host terminal.
- Sits beside the CPU top level, fed directly by its a0 output.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per UART bit. Integer ≥2. Use 868 for 100 MHz / 115200.
- FIFO_DEPTH, 4, number of 32-bit words queued. Power of two, ≥2.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- a0  input  32  CPU a0 register value.
- capture_en  input  1  1 = a0 changes are queued; 0 = ignored.
- clear_ovf  input  1  synchronous clear of overflow.
- tx  output  1  UART serial line, idle high.
- busy  output  1  1 while a frame is in flight or the FIFO is non-empty.
- overflow  output  1  sticky: a change was dropped because the FIFO was full.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE.
  - last_a0=0, FIFO pointers 0.
  - Applies immediately, including mid-frame; no partial frame resumes after reset.
- Change detect:
  - Each edge, a push is requested when capture_en=1 and a0 != last_a0.
  - last_a0 <= a0 every edge, regardless of capture_en or whether the push is accepted.
  - A value held for many cycles is queued once. A→B→A queues B then A.
- FIFO:
  - Circular buffer with separate rd/wr pointers wrapping modulo FIFO_DEPTH, plus a count register.
  - Push when not full: write, count+1.
  - Pop, only by the FSM: count-1.
  - Push and pop on the same edge: both occur, count unchanged. This holds when full: the push is accepted, no overflow.
  - Push when full with no same-edge pop: value dropped, overflow <= 1.
  - overflow clears only on clear_ovf=1 or reset. If clear_ovf and a new drop coincide, overflow=1 (set wins).
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count>0: pop head into word register, byte_idx=0, go to START. tx is registered, so it goes low on that same edge.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits of byte word[31-8*byte_idx -: 8], LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte_idx<3: byte_idx+1, go to START.
    - byte_idx==3 and count>0: pop, go to START, no idle gap.
    - otherwise go to IDLE.
- Timing:
  - Latency: a0 change sampled at edge E0 (entry written); tx falls at edge E1.
  - One byte = 10*CLKS_PER_BIT cycles; one word = 40*CLKS_PER_BIT cycles.
- busy = (FSM != IDLE) | (count != 0), registered-equivalent timing. Not asserted in the E0→E1 window only if count is still 0.
- The word register is loaded only on a pop; FIFO writes never disturb a frame in flight.

Test Plan:
- Single change, CLKS_PER_BIT=4, a0 0→0x12345678 held:
  - Byte sequence 0x12, 0x34, 0x56, 0x78.
  - tx low 1 cycle after capture.
  - First byte tx pattern per 4-cycle slot: 0, 0,1,0,0,1,0,0,0, 1.
  - busy high 160 cycles, then 0; exactly one word sent.
- a0 held at 0 after reset, capture_en=1, 500 cycles:
  - tx stays 1, busy=0, fifo_count=0.
- Burst, FIFO_DEPTH=4: a0 = 1,2,3,4,5,6 on consecutive cycles.
  - 1 popped immediately; 2–5 fill FIFO (fifo_count=4).
  - 6 dropped, overflow=1.
  - Output words 1,2,3,4,5 back-to-back with no idle cycle between words.
- Full FIFO, new a0 change on the edge STOP of a word's 4th byte pops:
  - Push accepted, fifo_count stays 4, overflow stays 0.
- rst low mid-DATA of the second byte:
  - tx=1 within the same cycle (asynchronous).
  - fifo_count=0, overflow=0.
  - After release with a0 unchanged and nonzero, that value is re-queued and sent once (last_a0 was reset to 0).
- capture_en=0 while a0 toggles 10 times, then capture_en=1 with a0 stable:
  - Nothing sent.
  - clear_ovf pulse clears a previously set overflow.

Source files
------------

// File: rtl/a0_uart_tx.sv
// a0_uart_tx: queues every change of the CPU a0 register in a small FIFO and
// streams each queued word as four 8N1 UART bytes, most significant byte first.
module a0_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [31:0]                   a0,
    input  logic                          capture_en,
    input  logic                          clear_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    state_t         r_state;
    logic [CW-1:0]  r_clk_cnt;
    logic [2:0]     r_bit_idx;
    logic [1:0]     r_byte_idx;
    logic [31:0]    r_word;
    logic           r_tx;
    logic           r_busy;
    logic           r_overflow;
    logic [AW:0]    r_count;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [31:0]    r_last_a0;
    logic [31:0]    r_mem [FIFO_DEPTH];

    state_t         w_state_nxt;
    logic [CW-1:0]  w_clk_cnt_nxt;
    logic [2:0]     w_bit_idx_nxt;
    logic [1:0]     w_byte_idx_nxt;
    logic [31:0]    w_word_nxt;
    logic           w_tx_nxt;
    logic           w_pop;
    logic           w_push_req;
    logic           w_full;
    logic           w_nempty;
    logic           w_push;
    logic           w_drop;
    logic [AW:0]    w_count_nxt;
    logic           w_overflow_nxt;
    logic           w_busy_nxt;
    logic           w_bit_end;
    logic [7:0]     w_cur_byte;
    logic [2:0]     w_bit_idx_inc;
    logic [31:0]    w_head;

    assign w_push_req    = capture_en & (a0 != r_last_a0);
    assign w_full        = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_nempty      = (r_count != {(AW+1){1'b0}});
    assign w_bit_end     = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_cur_byte    = sel_byte(r_word, r_byte_idx);
    assign w_bit_idx_inc = r_bit_idx + 3'd1;
    assign w_head        = r_mem[r_rd_ptr];

    // FIFO push/drop decision, occupancy and sticky overflow next-state
    always_comb begin
        w_push         = 1'b0;
        w_drop         = 1'b0;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        // A same-edge pop frees a slot, so a full FIFO still accepts the push.
        if (w_push_req && (!w_full || w_pop)) begin
            w_push = 1'b1;
        end else begin
            w_drop = w_push_req;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_drop) begin
            w_overflow_nxt = 1'b1;
        end else if (clear_ovf) begin
            w_overflow_nxt = 1'b0;
        end else begin
            w_overflow_nxt = r_overflow;
        end
        w_busy_nxt = (w_state_nxt != ST_IDLE) | (w_count_nxt != {(AW+1){1'b0}});
    end

    // TX framing FSM: next state, bit timing and the registered tx level
    always_comb begin
        w_state_nxt    = r_state;
        w_clk_cnt_nxt  = r_clk_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_word_nxt     = r_word;
        w_tx_nxt       = 1'b1;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_nempty) begin
                    w_pop          = 1'b1;
                    w_word_nxt     = w_head;
                    w_byte_idx_nxt = 2'd0;
                    w_clk_cnt_nxt  = CW'(0);
                    w_state_nxt    = ST_START;
                    w_tx_nxt       = 1'b0;
                end else begin
                    w_tx_nxt = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = CW'(0);
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = ST_DATA;
                    w_tx_nxt      = w_cur_byte[0];
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                    w_tx_nxt      = 1'b0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = CW'(0);
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_idx_nxt = w_bit_idx_inc;
                        w_tx_nxt      = w_cur_byte[w_bit_idx_inc];
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                    w_tx_nxt      = w_cur_byte[r_bit_idx];
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = CW'(0);
                    if (r_byte_idx != 2'd3) begin
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                        w_state_nxt    = ST_START;
                        w_tx_nxt       = 1'b0;
                    end else if (w_nempty) begin
                        // Chain straight into the next queued word with no idle gap.
                        w_pop          = 1'b1;
                        w_word_nxt     = w_head;
                        w_byte_idx_nxt = 2'd0;
                        w_state_nxt    = ST_START;
                        w_tx_nxt       = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                    w_tx_nxt      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // FSM, framing and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_clk_cnt  <= CW'(0);
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 32'h0000_0000;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_word     <= w_word_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // FIFO pointers, occupancy, overflow flag and change-detect history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {(AW+1){1'b0}};
            r_overflow <= 1'b0;
            r_last_a0  <= 32'h0000_0000;
        end else begin
            r_wr_ptr   <= w_push ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
            r_rd_ptr   <= w_pop  ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_last_a0  <= a0;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 32'h0000_0000;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= a0;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_a0_uart_tx.sv
// Self-checking bench for a0_uart_tx: a table of single-word captures plus
// hand-written burst, full-FIFO, reset and overflow sequences.
module tb_a0_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [31:0] a0;
    logic        capture_en;
    logic        clear_ovf;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_checks;
    int n_fail;
    int cyc;
    int mon_frame_err;
    logic [31:0] rx_q[$];
    int          rx_start_q[$];

    typedef struct {
        logic [31:0] a0;
        logic        cap;
        logic [2:0]  exp_cnt;
        logic        exp_tx_e1;
        int          exp_busy_len;
        int          exp_nwords;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[7];

    a0_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .a0         (a0),
        .capture_en (capture_en),
        .clear_ovf  (clear_ovf),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver: samples mid-bit, assembles MSB-first words
    initial begin : monitor
        logic [31:0] word;
        logic [7:0]  b;
        int nb, bstart, wstart, slot;
        logic bad, aborted;
        nb = 0; word = 32'h0; wstart = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                nb = 0;
            end else if (tx == 1'b0) begin
                bstart = cyc; bad = 1'b0; aborted = 1'b0; b = 8'h00;
                for (int k = 1; k <= 9*CPB + CPB/2; k++) begin
                    @(negedge clk);
                    if (!rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % CPB == CPB/2) begin
                        slot = k / CPB;
                        if (slot == 0)      bad = bad | tx;
                        else if (slot == 9) bad = bad | ~tx;
                        else                b[slot-1] = tx;
                    end
                end
                if (aborted) begin
                    nb = 0;
                end else begin
                    if (bad) mon_frame_err++;
                    if (nb == 0) wstart = bstart;
                    word = {word[23:0], b};
                    nb++;
                    if (nb == 4) begin
                        rx_q.push_back(word);
                        rx_start_q.push_back(wstart);
                        nb = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check("idle_reached", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h1234_5678, 1'b1, 3'd1, 1'b0, 160, 1, 32'h1234_5678};
        vecs[1] = '{32'h0000_0001, 1'b1, 3'd1, 1'b0, 160, 1, 32'h0000_0001};
        vecs[2] = '{32'hDEAD_0000, 1'b0, 3'd0, 1'b1,   0, 0, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 1'b1, 3'd1, 1'b0, 160, 1, 32'hFFFF_FFFF};
        vecs[4] = '{32'h8000_0000, 1'b1, 3'd1, 1'b0, 160, 1, 32'h8000_0000};
        vecs[5] = '{32'hA55A_3CC3, 1'b1, 3'd1, 1'b0, 160, 1, 32'hA55A_3CC3};
        vecs[6] = '{32'hA55A_3CC3, 1'b1, 3'd0, 1'b1,   0, 0, 32'h0000_0000};

        rst = 1'b0; a0 = 32'h0; capture_en = 1'b1; clear_ovf = 1'b0;
        repeat (3) tick();
        check("rst_tx", {31'h0, tx}, 32'h1);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_cnt", 32'(fifo_count), 32'h0);
        #4 rst = 1'b1;

        // a0 held at zero: nothing may be queued or sent
        for (int i = 0; i < 500; i++) begin
            tick();
            check("idle_tx", {31'h0, tx}, 32'h1);
            check("idle_busy", {31'h0, busy}, 32'h0);
            check("idle_cnt", 32'(fifo_count), 32'h0);
        end

        // Table of single captures
        for (int i = 0; i < 7; i++) begin
            rx_q.delete(); rx_start_q.delete();
            capture_en = vecs[i].cap;
            a0 = vecs[i].a0;
            tick();
            check("cnt_after_capture", 32'(fifo_count), 32'(vecs[i].exp_cnt));
            check("tx_at_capture", {31'h0, tx}, 32'h1);
            tick();
            check("tx_latency", {31'h0, tx}, {31'h0, vecs[i].exp_tx_e1});
            wait_idle(400, n);
            check("busy_len", n, vecs[i].exp_busy_len);
            check("nwords", rx_q.size(), vecs[i].exp_nwords);
            if (vecs[i].exp_nwords > 0 && rx_q.size() > 0)
                check("word", rx_q[0], vecs[i].exp_word);
        end

        // Burst 1..6: 1 popped at once, 2..5 fill the FIFO, 6 dropped
        rx_q.delete(); rx_start_q.delete();
        capture_en = 1'b1;
        for (int v = 1; v <= 6; v++) begin
            a0 = 32'(v);
            tick();
        end
        check("burst_cnt_full", 32'(fifo_count), 32'd4);
        check("burst_ovf", {31'h0, overflow}, 32'h1);
        wait_idle(2000, n);
        check("burst_busy_len", n, 796);
        check("burst_nwords", rx_q.size(), 5);
        for (int j = 0; j < 5 && j < rx_q.size(); j++) check("burst_word", rx_q[j], 32'(j + 1));
        for (int j = 1; j < 5 && j < rx_start_q.size(); j++)
            check("burst_gap", rx_start_q[j] - rx_start_q[j-1], 160);
        check("ovf_sticky", {31'h0, overflow}, 32'h1);
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        check("ovf_cleared", {31'h0, overflow}, 32'h0);

        // Full FIFO: push on the edge the last STOP pops
        rx_q.delete(); rx_start_q.delete();
        for (int v = 1; v <= 5; v++) begin
            a0 = 32'(v * 17);
            tick();
        end
        repeat (156) tick();
        check("full_pre_cnt", 32'(fifo_count), 32'd4);
        a0 = 32'h66;
        tick();
        check("full_pushpop_cnt", 32'(fifo_count), 32'd4);
        check("full_pushpop_ovf", {31'h0, overflow}, 32'h0);
        wait_idle(2000, n);
        check("full_busy_len", n, 800);
        check("full_nwords", rx_q.size(), 6);
        for (int j = 0; j < 6 && j < rx_q.size(); j++) check("full_word", rx_q[j], 32'((j + 1) * 17));

        // Reset mid-DATA of the second byte with a full, overflowed FIFO
        a0 = 32'hCAFE_BABE;
        tick();
        tick();
        check("rst_seq_start", {31'h0, tx}, 32'h0);
        for (int v = 1; v <= 5; v++) begin
            a0 = 32'hC000_0000 + 32'(v);
            tick();
        end
        check("rst_seq_cnt", 32'(fifo_count), 32'd4);
        check("rst_seq_ovf", {31'h0, overflow}, 32'h1);
        repeat (40) tick();
        check("rst_seq_tx_low", {31'h0, tx}, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("async_tx", {31'h0, tx}, 32'h1);
        check("async_busy", {31'h0, busy}, 32'h0);
        check("async_ovf", {31'h0, overflow}, 32'h0);
        check("async_cnt", 32'(fifo_count), 32'h0);
        rx_q.delete(); rx_start_q.delete();
        #20 rst = 1'b1;
        tick();
        check("requeue_cnt", 32'(fifo_count), 32'd1);
        tick();
        check("requeue_tx", {31'h0, tx}, 32'h0);
        wait_idle(400, n);
        check("requeue_busy_len", n, 160);
        check("requeue_nwords", rx_q.size(), 1);
        if (rx_q.size() > 0) check("requeue_word", rx_q[0], 32'hC000_0005);

        // capture_en low while a0 toggles, then enable with a0 stable
        rx_q.delete(); rx_start_q.delete();
        capture_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a0 = 32'h100 + 32'(i);
            tick();
            check("dis_cnt", 32'(fifo_count), 32'h0);
        end
        capture_en = 1'b1;
        repeat (200) tick();
        check("dis_nwords", rx_q.size(), 0);
        check("dis_busy", {31'h0, busy}, 32'h0);
        check("dis_tx", {31'h0, tx}, 32'h1);

        // Drop coinciding with clear_ovf: set wins; a later pulse clears
        for (int v = 1; v <= 5; v++) begin
            a0 = 32'h200 + 32'(v);
            tick();
        end
        a0 = 32'h206; clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_set_wins", {31'h0, overflow}, 32'h1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_clear_pulse", {31'h0, overflow}, 32'h0);
        wait_idle(2000, n);
        check("setwin_nwords", rx_q.size(), 5);
        check("frame_errors", mon_frame_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
